// File: rtl/pipeline_defs.sv
// Shared pipeline definitions for the decode and execute stages: default widths,
// ALU op-codes and the bundle of one-bit decoded controls.
package pipeline_defs;

  localparam int XLEN_DEFAULT    = 32;
  localparam int ALUOP_W_DEFAULT = 4;
  localparam int REG_IDX_W       = 5;
  localparam int CTRL_W          = 6;

  typedef enum logic [ALUOP_W_DEFAULT-1:0] {
    ALU_ADD = 4'd0,
    ALU_SUB = 4'd1,
    ALU_AND = 4'd2,
    ALU_OR  = 4'd3,
    ALU_XOR = 4'd4,
    ALU_SLT = 4'd5,
    ALU_SLL = 4'd6,
    ALU_SRL = 4'd7,
    ALU_SRA = 4'd8,
    ALU_LUI = 4'd9
  } alu_op_e;

  // Field order matches the bit order used when controls are packed for transport.
  typedef struct packed {
    logic alu_src;
    logic mem_read;
    logic mem_write;
    logic reg_write;
    logic mem_to_reg;
    logic branch;
  } ctrl_t;

  localparam ctrl_t CTRL_NOP = '0;

endpackage

// File: rtl/load_use_detect.sv
// Load-use hazard compare: a load in EX whose destination is read by the
// instruction currently in ID forces a one-cycle bubble.
module load_use_detect
  import pipeline_defs::*;
(
  input  logic                 id_valid,
  input  logic [REG_IDX_W-1:0] id_rs1,
  input  logic [REG_IDX_W-1:0] id_rs2,
  input  logic                 id_uses_rs2,
  input  logic                 ex_valid,
  input  logic                 ex_mem_read,
  input  logic [REG_IDX_W-1:0] ex_rd,
  output logic                 stall
);

  logic load_in_ex;
  logic rs1_hit;
  logic rs2_hit;

  // x0 is never a real destination, so a load to x0 cannot create a hazard.
  assign load_in_ex = ex_valid & ex_mem_read & (ex_rd != '0);
  assign rs1_hit    = (ex_rd == id_rs1);
  assign rs2_hit    = id_uses_rs2 & (ex_rd == id_rs2);
  assign stall      = id_valid & load_in_ex & (rs1_hit | rs2_hit);

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with writeback bypass on the operands, load-use
// stall generation, flush-to-bubble and a saturating stall-cycle counter.
module id_ex_stage
  import pipeline_defs::*;
#(
  parameter int XLEN    = XLEN_DEFAULT,
  parameter int ALUOP_W = ALUOP_W_DEFAULT,
  parameter int CNT_W   = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 id_valid,
  input  logic [XLEN-1:0]      id_pc,
  input  logic [XLEN-1:0]      id_imm,
  input  logic [REG_IDX_W-1:0] id_rs1,
  input  logic [REG_IDX_W-1:0] id_rs2,
  input  logic [REG_IDX_W-1:0] id_rd,
  input  logic                 id_uses_rs2,
  input  logic [XLEN-1:0]      read_data_1,
  input  logic [XLEN-1:0]      read_data_2,
  input  logic [ALUOP_W-1:0]   id_alu_op,
  input  logic                 id_alu_src,
  input  logic                 id_mem_read,
  input  logic                 id_mem_write,
  input  logic                 id_reg_write,
  input  logic                 id_mem_to_reg,
  input  logic                 id_branch,
  input  logic                 wb_reg_write,
  input  logic [REG_IDX_W-1:0] wb_write_reg_num,
  input  logic [XLEN-1:0]      wb_write_data,
  input  logic                 flush,
  output logic                 stall,
  output logic                 ex_valid,
  output logic [XLEN-1:0]      ex_pc,
  output logic [XLEN-1:0]      ex_imm,
  output logic [XLEN-1:0]      ex_op1,
  output logic [XLEN-1:0]      ex_op2,
  output logic [REG_IDX_W-1:0] ex_rs1,
  output logic [REG_IDX_W-1:0] ex_rs2,
  output logic [REG_IDX_W-1:0] ex_rd,
  output logic [ALUOP_W-1:0]   ex_alu_op,
  output logic                 ex_alu_src,
  output logic                 ex_mem_read,
  output logic                 ex_mem_write,
  output logic                 ex_reg_write,
  output logic                 ex_mem_to_reg,
  output logic                 ex_branch,
  output logic [CNT_W-1:0]     stall_count
);

  ctrl_t                id_ctrl;
  ctrl_t                ex_ctrl_q, ex_ctrl_d;
  logic                 ex_valid_q, ex_valid_d;
  logic [XLEN-1:0]      ex_pc_q, ex_pc_d;
  logic [XLEN-1:0]      ex_imm_q, ex_imm_d;
  logic [XLEN-1:0]      ex_op1_q, ex_op1_d;
  logic [XLEN-1:0]      ex_op2_q, ex_op2_d;
  logic [REG_IDX_W-1:0] ex_rs1_q, ex_rs1_d;
  logic [REG_IDX_W-1:0] ex_rs2_q, ex_rs2_d;
  logic [REG_IDX_W-1:0] ex_rd_q, ex_rd_d;
  logic [ALUOP_W-1:0]   ex_alu_op_q, ex_alu_op_d;
  logic [CNT_W-1:0]     stall_count_q, stall_count_d;
  logic [XLEN-1:0]      op1_sel, op2_sel;
  logic                 hazard;

  assign id_ctrl = '{alu_src: id_alu_src, mem_read: id_mem_read, mem_write: id_mem_write,
                     reg_write: id_reg_write, mem_to_reg: id_mem_to_reg, branch: id_branch};

  load_use_detect u_load_use_detect (
    .id_valid    (id_valid),
    .id_rs1      (id_rs1),
    .id_rs2      (id_rs2),
    .id_uses_rs2 (id_uses_rs2),
    .ex_valid    (ex_valid_q),
    .ex_mem_read (ex_ctrl_q.mem_read),
    .ex_rd       (ex_rd_q),
    .stall       (hazard)
  );

  // A same-cycle writeback is not yet visible in read_data, so it is forwarded here.
  always_comb begin
    op1_sel = read_data_1;
    op2_sel = read_data_2;
    if (id_rs1 == '0) begin
      op1_sel = '0;
    end else if (wb_reg_write && (wb_write_reg_num == id_rs1)) begin
      op1_sel = wb_write_data;
    end
    if (id_rs2 == '0) begin
      op2_sel = '0;
    end else if (wb_reg_write && (wb_write_reg_num == id_rs2)) begin
      op2_sel = wb_write_data;
    end
  end

  always_comb begin
    ex_valid_d    = ex_valid_q;
    ex_pc_d       = ex_pc_q;
    ex_imm_d      = ex_imm_q;
    ex_op1_d      = ex_op1_q;
    ex_op2_d      = ex_op2_q;
    ex_rs1_d      = ex_rs1_q;
    ex_rs2_d      = ex_rs2_q;
    ex_rd_d       = ex_rd_q;
    ex_alu_op_d   = ex_alu_op_q;
    ex_ctrl_d     = ex_ctrl_q;
    stall_count_d = stall_count_q;
    // Bubble keeps the data fields; only validity and controls are killed.
    if (flush || hazard) begin
      ex_valid_d  = 1'b0;
      ex_ctrl_d   = CTRL_NOP;
      ex_alu_op_d = '0;
    end else begin
      ex_valid_d  = id_valid;
      ex_pc_d     = id_pc;
      ex_imm_d    = id_imm;
      ex_op1_d    = op1_sel;
      ex_op2_d    = op2_sel;
      ex_rs1_d    = id_rs1;
      ex_rs2_d    = id_rs2;
      ex_rd_d     = id_rd;
      ex_ctrl_d   = id_valid ? id_ctrl : CTRL_NOP;
      ex_alu_op_d = id_valid ? id_alu_op : '0;
    end
    if (hazard && (stall_count_q != '1)) begin
      stall_count_d = stall_count_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ex_valid_q    <= 1'b0;
      ex_pc_q       <= '0;
      ex_imm_q      <= '0;
      ex_op1_q      <= '0;
      ex_op2_q      <= '0;
      ex_rs1_q      <= '0;
      ex_rs2_q      <= '0;
      ex_rd_q       <= '0;
      ex_alu_op_q   <= '0;
      ex_ctrl_q     <= CTRL_NOP;
      stall_count_q <= '0;
    end else begin
      ex_valid_q    <= ex_valid_d;
      ex_pc_q       <= ex_pc_d;
      ex_imm_q      <= ex_imm_d;
      ex_op1_q      <= ex_op1_d;
      ex_op2_q      <= ex_op2_d;
      ex_rs1_q      <= ex_rs1_d;
      ex_rs2_q      <= ex_rs2_d;
      ex_rd_q       <= ex_rd_d;
      ex_alu_op_q   <= ex_alu_op_d;
      ex_ctrl_q     <= ex_ctrl_d;
      stall_count_q <= stall_count_d;
    end
  end

  assign stall         = hazard;
  assign ex_valid      = ex_valid_q;
  assign ex_pc         = ex_pc_q;
  assign ex_imm        = ex_imm_q;
  assign ex_op1        = ex_op1_q;
  assign ex_op2        = ex_op2_q;
  assign ex_rs1        = ex_rs1_q;
  assign ex_rs2        = ex_rs2_q;
  assign ex_rd         = ex_rd_q;
  assign ex_alu_op     = ex_alu_op_q;
  assign ex_alu_src    = ex_ctrl_q.alu_src;
  assign ex_mem_read   = ex_ctrl_q.mem_read;
  assign ex_mem_write  = ex_ctrl_q.mem_write;
  assign ex_reg_write  = ex_ctrl_q.reg_write;
  assign ex_mem_to_reg = ex_ctrl_q.mem_to_reg;
  assign ex_branch     = ex_ctrl_q.branch;
  assign stall_count   = stall_count_q;

endmodule

// File: tb/tb_id_ex_stage.sv
// Bench for id_ex_stage: directed hazard/bypass/flush/reset scenarios plus a
// randomized run against a behavioural model; a CNT_W=4 copy checks saturation.
module tb_id_ex_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic        id_valid, id_uses_rs2, flush, wb_reg_write;
  logic [31:0] id_pc, id_imm, read_data_1, read_data_2, wb_write_data;
  logic [4:0]  id_rs1, id_rs2, id_rd, wb_write_reg_num;
  logic [3:0]  id_alu_op;
  logic [5:0]  id_ctrl;  // {alu_src, mem_read, mem_write, reg_write, mem_to_reg, branch}

  logic        stall, ex_valid;
  logic [31:0] ex_pc, ex_imm, ex_op1, ex_op2;
  logic [4:0]  ex_rs1, ex_rs2, ex_rd;
  logic [3:0]  ex_alu_op;
  logic        ex_alu_src, ex_mem_read, ex_mem_write, ex_reg_write, ex_mem_to_reg, ex_branch;
  logic [15:0] stall_count;

  logic        s_stall, s_valid;
  logic [31:0] s_pc, s_imm, s_op1, s_op2;
  logic [4:0]  s_rs1, s_rs2, s_rd;
  logic [3:0]  s_alu_op;
  logic        s_alu_src, s_mem_read, s_mem_write, s_reg_write, s_mem_to_reg, s_branch;
  logic [3:0]  s_count;

  int n_vec = 0;
  int n_err = 0;

  // Behavioural model of what EX should hold.
  logic        m_valid;
  logic [31:0] m_pc, m_imm, m_op1, m_op2;
  logic [4:0]  m_rs1, m_rs2, m_rd;
  logic [3:0]  m_alu;
  logic [5:0]  m_ctrl;
  int          m_stalls;

  localparam logic [5:0] C_LW  = 6'b110110;
  localparam logic [5:0] C_ADD = 6'b000100;

  always #5 clk = ~clk;

  id_ex_stage dut (
    .clk(clk), .reset(reset), .id_valid(id_valid), .id_pc(id_pc), .id_imm(id_imm),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd), .id_uses_rs2(id_uses_rs2),
    .read_data_1(read_data_1), .read_data_2(read_data_2), .id_alu_op(id_alu_op),
    .id_alu_src(id_ctrl[5]), .id_mem_read(id_ctrl[4]), .id_mem_write(id_ctrl[3]),
    .id_reg_write(id_ctrl[2]), .id_mem_to_reg(id_ctrl[1]), .id_branch(id_ctrl[0]),
    .wb_reg_write(wb_reg_write), .wb_write_reg_num(wb_write_reg_num), .wb_write_data(wb_write_data),
    .flush(flush), .stall(stall), .ex_valid(ex_valid), .ex_pc(ex_pc), .ex_imm(ex_imm),
    .ex_op1(ex_op1), .ex_op2(ex_op2), .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_rd(ex_rd),
    .ex_alu_op(ex_alu_op), .ex_alu_src(ex_alu_src), .ex_mem_read(ex_mem_read),
    .ex_mem_write(ex_mem_write), .ex_reg_write(ex_reg_write), .ex_mem_to_reg(ex_mem_to_reg),
    .ex_branch(ex_branch), .stall_count(stall_count)
  );

  id_ex_stage #(.CNT_W(4)) dut_sat (
    .clk(clk), .reset(reset), .id_valid(id_valid), .id_pc(id_pc), .id_imm(id_imm),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd), .id_uses_rs2(id_uses_rs2),
    .read_data_1(read_data_1), .read_data_2(read_data_2), .id_alu_op(id_alu_op),
    .id_alu_src(id_ctrl[5]), .id_mem_read(id_ctrl[4]), .id_mem_write(id_ctrl[3]),
    .id_reg_write(id_ctrl[2]), .id_mem_to_reg(id_ctrl[1]), .id_branch(id_ctrl[0]),
    .wb_reg_write(wb_reg_write), .wb_write_reg_num(wb_write_reg_num), .wb_write_data(wb_write_data),
    .flush(flush), .stall(s_stall), .ex_valid(s_valid), .ex_pc(s_pc), .ex_imm(s_imm),
    .ex_op1(s_op1), .ex_op2(s_op2), .ex_rs1(s_rs1), .ex_rs2(s_rs2), .ex_rd(s_rd),
    .ex_alu_op(s_alu_op), .ex_alu_src(s_alu_src), .ex_mem_read(s_mem_read),
    .ex_mem_write(s_mem_write), .ex_reg_write(s_reg_write), .ex_mem_to_reg(s_mem_to_reg),
    .ex_branch(s_branch), .stall_count(s_count)
  );

  wire [153:0] dut_state = {ex_valid, ex_pc, ex_imm, ex_op1, ex_op2, ex_rs1, ex_rs2, ex_rd, ex_alu_op,
                            ex_alu_src, ex_mem_read, ex_mem_write, ex_reg_write, ex_mem_to_reg, ex_branch};

  function automatic logic [153:0] model_state();
    return {m_valid, m_pc, m_imm, m_op1, m_op2, m_rs1, m_rs2, m_rd, m_alu, m_ctrl};
  endfunction

  function automatic logic [15:0] exp_count16();
    return (m_stalls > 65535) ? 16'hffff : 16'(m_stalls);
  endfunction

  // A load in EX writing a nonzero register that the ID instruction reads.
  function automatic logic model_stall();
    logic reads_it;
    reads_it = (m_rd == id_rs1) || (id_uses_rs2 && (m_rd == id_rs2));
    return id_valid && m_valid && m_ctrl[4] && (m_rd != 5'd0) && reads_it;
  endfunction

  function automatic logic [31:0] operand(input logic [4:0] idx, input logic [31:0] rf_val);
    if (idx == 5'd0) return 32'd0;
    if (wb_reg_write && wb_write_reg_num == idx) return wb_write_data;
    return rf_val;
  endfunction

  task automatic model_reset();
    m_valid = 0; m_pc = 0; m_imm = 0; m_op1 = 0; m_op2 = 0;
    m_rs1 = 0; m_rs2 = 0; m_rd = 0; m_alu = 0; m_ctrl = 0; m_stalls = 0;
  endtask

  // One rising edge; the model advances using the inputs present at the edge.
  task automatic tick();
    logic st;
    st = model_stall();
    @(posedge clk);
    if (st) m_stalls++;
    if (flush || st) begin
      m_valid = 0; m_ctrl = 0; m_alu = 0;
    end else begin
      m_valid = id_valid; m_pc = id_pc; m_imm = id_imm;
      m_op1 = operand(id_rs1, read_data_1); m_op2 = operand(id_rs2, read_data_2);
      m_rs1 = id_rs1; m_rs2 = id_rs2; m_rd = id_rd;
      m_ctrl = id_valid ? id_ctrl : 6'd0;
      m_alu = id_valid ? id_alu_op : 4'd0;
    end
    #1;
  endtask

  task automatic set_id(input logic v, input logic [4:0] rs1, input logic [4:0] rs2,
                        input logic [4:0] rd, input logic u2, input logic [31:0] r1,
                        input logic [31:0] r2, input logic [5:0] ctrl);
    id_valid = v; id_rs1 = rs1; id_rs2 = rs2; id_rd = rd; id_uses_rs2 = u2;
    read_data_1 = r1; read_data_2 = r2; id_ctrl = ctrl;
    id_alu_op = 4'($urandom_range(1, 9)); id_pc = $urandom; id_imm = $urandom;
  endtask

  task automatic test_reset();
    reset = 0; flush = 0; wb_reg_write = 0; wb_write_reg_num = 0; wb_write_data = 0;
    set_id(1, 5'd3, 5'd3, 5'd3, 1, 32'd1, 32'd2, C_LW);
    model_reset();
    #12;
    n_vec++;
    if (dut_state !== 154'd0 || stall_count !== 16'd0) begin
      n_err++; $display("FAIL reset_hold state=%h cnt=%0d expected 0/0", dut_state, stall_count);
    end
    @(negedge clk) reset = 1;
    #1;
    n_vec++;
    if (stall !== 1'b0) begin
      n_err++; $display("FAIL stall_after_reset got=%b expected 0", stall);
    end
    tick();
    n_vec++;
    if (dut_state !== model_state()) begin
      n_err++; $display("FAIL first_load got=%h expected %h", dut_state, model_state());
    end
  endtask

  task automatic test_bypass();
    set_id(1, 5'd1, 5'd2, 5'd5, 1, 32'd7, 32'd9, C_ADD);
    wb_reg_write = 1; wb_write_reg_num = 5'd2; wb_write_data = 32'h20;
    tick();
    wb_reg_write = 0;
    n_vec++;
    if (ex_op1 !== 32'd7 || ex_op2 !== 32'h20 || ex_rd !== 5'd5 || ex_valid !== 1'b1) begin
      n_err++; $display("FAIL wb_bypass op1=%h op2=%h rd=%0d v=%b expected 7/20/5/1",
                        ex_op1, ex_op2, ex_rd, ex_valid);
    end
  endtask

  task automatic test_load_use();
    set_id(1, 5'd1, 5'd0, 5'd3, 0, 32'd4, 32'd0, C_LW);
    tick();
    set_id(1, 5'd3, 5'd1, 5'd4, 1, 32'd11, 32'd12, C_ADD);
    #1;
    n_vec++;
    if (stall !== 1'b1) begin
      n_err++; $display("FAIL load_use_stall got=%b expected 1", stall);
    end
    tick();
    n_vec++;
    if (ex_valid !== 1'b0 || ex_mem_read !== 1'b0 || ex_reg_write !== 1'b0 || ex_alu_op !== 4'd0
        || stall_count !== exp_count16()) begin
      n_err++; $display("FAIL load_use_bubble v=%b mr=%b rw=%b op=%0d cnt=%0d expected 0/0/0/0/%0d",
                        ex_valid, ex_mem_read, ex_reg_write, ex_alu_op, stall_count, exp_count16());
    end
    n_vec++;
    if (stall !== 1'b0) begin
      n_err++; $display("FAIL stall_release got=%b expected 0", stall);
    end
    tick();
    n_vec++;
    if (ex_valid !== 1'b1 || ex_rd !== 5'd4 || ex_op1 !== 32'd11 || dut_state !== model_state()) begin
      n_err++; $display("FAIL held_reload got=%h expected %h", dut_state, model_state());
    end
  endtask

  task automatic test_x0();
    set_id(1, 5'd2, 5'd0, 5'd0, 0, 32'd5, 32'd0, C_LW);
    tick();
    set_id(1, 5'd0, 5'd0, 5'd6, 1, 32'd1, 32'd1, C_ADD);
    #1;
    n_vec++;
    if (stall !== 1'b0) begin
      n_err++; $display("FAIL x0_no_stall got=%b expected 0", stall);
    end
    tick();
    n_vec++;
    if (ex_op1 !== 32'd0 || ex_op2 !== 32'd0 || ex_valid !== 1'b1) begin
      n_err++; $display("FAIL x0_operand op1=%h op2=%h v=%b expected 0/0/1", ex_op1, ex_op2, ex_valid);
    end
  endtask

  task automatic test_flush();
    set_id(1, 5'd1, 5'd0, 5'd3, 0, 32'd8, 32'd0, C_LW);
    tick();
    set_id(1, 5'd3, 5'd1, 5'd4, 1, 32'd1, 32'd2, C_ADD);
    flush = 1;
    #1;
    n_vec++;
    if (stall !== 1'b1) begin
      n_err++; $display("FAIL flush_stall got=%b expected 1", stall);
    end
    tick();
    n_vec++;
    if (ex_valid !== 1'b0 || ex_mem_read !== 1'b0 || stall_count !== exp_count16()) begin
      n_err++; $display("FAIL flush_and_stall v=%b mr=%b cnt=%0d expected 0/0/%0d",
                        ex_valid, ex_mem_read, stall_count, exp_count16());
    end
    set_id(1, 5'd1, 5'd2, 5'd6, 1, 32'd3, 32'd4, C_ADD);
    tick();
    n_vec++;
    if (ex_valid !== 1'b0 || ex_reg_write !== 1'b0 || dut_state !== model_state()) begin
      n_err++; $display("FAIL flush_valid got=%h expected %h", dut_state, model_state());
    end
    flush = 0;
  endtask

  task automatic test_reset_mid_stall();
    set_id(1, 5'd1, 5'd0, 5'd3, 0, 32'd8, 32'd0, C_LW);
    tick();
    set_id(1, 5'd3, 5'd1, 5'd4, 1, 32'd21, 32'd22, C_ADD);
    #2;
    reset = 0;
    #1;
    model_reset();
    n_vec++;
    if (stall !== 1'b0 || dut_state !== 154'd0 || stall_count !== 16'd0) begin
      n_err++; $display("FAIL async_reset stall=%b state=%h cnt=%0d expected 0/0/0",
                        stall, dut_state, stall_count);
    end
    @(negedge clk) reset = 1;
    tick();
    n_vec++;
    if (ex_valid !== 1'b1 || ex_rd !== 5'd4 || dut_state !== model_state()) begin
      n_err++; $display("FAIL post_reset_load got=%h expected %h", dut_state, model_state());
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      id_valid = ($urandom_range(0, 3) != 0);
      id_rs1 = 5'($urandom_range(0, 3)); id_rs2 = 5'($urandom_range(0, 3));
      id_rd = 5'($urandom_range(0, 3)); id_uses_rs2 = 1'($urandom_range(0, 1));
      id_ctrl = 6'($urandom); id_alu_op = 4'($urandom);
      id_pc = $urandom; id_imm = $urandom; read_data_1 = $urandom; read_data_2 = $urandom;
      wb_reg_write = 1'($urandom_range(0, 1)); wb_write_reg_num = 5'($urandom_range(0, 3));
      wb_write_data = $urandom;
      flush = ($urandom_range(0, 7) == 0);
      #1;
      n_vec++;
      if (stall !== model_stall()) begin
        n_err++; $display("FAIL rand_stall[%0d] got=%b expected %b", i, stall, model_stall());
      end
      tick();
      n_vec++;
      if (dut_state !== model_state() || stall_count !== exp_count16()) begin
        n_err++; $display("FAIL rand_state[%0d] got=%h/%0d expected %h/%0d",
                          i, dut_state, stall_count, model_state(), exp_count16());
      end
    end
    flush = 0; wb_reg_write = 0;
  endtask

  task automatic test_saturation();
    for (int i = 0; i < 20; i++) begin
      set_id(1, 5'd1, 5'd0, 5'd3, 0, 32'd8, 32'd0, C_LW);
      tick();
      set_id(1, 5'd3, 5'd1, 5'd4, 1, 32'd1, 32'd2, C_ADD);
      tick();
    end
    n_vec++;
    if (s_count !== 4'd15) begin
      n_err++; $display("FAIL sat_count got=%0d expected 15", s_count);
    end
    n_vec++;
    if (stall_count !== exp_count16()) begin
      n_err++; $display("FAIL wide_count got=%0d expected %0d", stall_count, exp_count16());
    end
  endtask

  initial begin
    test_reset();
    test_bypass();
    test_load_use();
    test_x0();
    test_flush();
    test_reset_mid_stall();
    test_random();
    test_saturation();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
